// File: rtl/tomasulo_regfile_pkg.sv
// Shared types and sizing for the register file and the reservation stations.
package tomasulo_pkg;

  localparam int unsigned N_REGISTER = 8;
  localparam int unsigned N_NUMBERS  = $clog2(N_REGISTER);
  localparam int unsigned N_SIZE     = 16;
  localparam int unsigned N_READ     = 3;
  localparam int unsigned TAG_W      = 3;
  localparam int unsigned CNT_W      = $clog2(N_REGISTER + 1);

  typedef logic [N_NUMBERS-1:0] reg_num_t;
  typedef logic [N_SIZE-1:0]    data_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef struct packed {
    data_t value;
    logic  busy;
    tag_t  tag;
  } entry_t;

  function automatic cnt_t popcount(input logic [N_REGISTER-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < N_REGISTER; i++) begin
      c = c + cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/tomasulo_regfile_if.sv
// Dispatch/CDB-facing bus of the register file; master is the core side.
interface tomasulo_regfile_if;
  import tomasulo_pkg::*;

  reg_num_t [N_READ-1:0] rd_num;
  data_t    [N_READ-1:0] rd_value;
  logic     [N_READ-1:0] rd_ready;
  tag_t     [N_READ-1:0] rd_tag;

  logic     alloc_valid;
  reg_num_t alloc_num;
  tag_t     alloc_tag;

  logic     cdb_valid;
  tag_t     cdb_tag;
  data_t    cdb_data;

  logic     flush;
  cnt_t     busy_count;

  modport master (
    output rd_num, alloc_valid, alloc_num, alloc_tag, cdb_valid, cdb_tag, cdb_data, flush,
    input  rd_value, rd_ready, rd_tag, busy_count
  );

  modport slave (
    input  rd_num, alloc_valid, alloc_num, alloc_tag, cdb_valid, cdb_tag, cdb_data, flush,
    output rd_value, rd_ready, rd_tag, busy_count
  );

endinterface

// File: rtl/tomasulo_regfile_entry.sv
// One architectural register: value plus rename status (busy, producer tag).
module reg_entry
  import tomasulo_pkg::*;
(
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   alloc_hit_i,
  input  tag_t   alloc_tag_i,
  input  logic   cdb_valid_i,
  input  tag_t   cdb_tag_i,
  input  data_t  cdb_data_i,
  input  logic   flush_i,
  output entry_t entry_o,
  output logic   busy_d_o
);

  entry_t entry_q, entry_d;
  logic   cdb_hit;

  assign cdb_hit = entry_q.busy && cdb_valid_i && (cdb_tag_i == entry_q.tag);

  // CDB value write survives flush and alloc; alloc overrides the busy clear.
  always_comb begin
    entry_d = entry_q;
    if (cdb_hit) begin
      entry_d.value = cdb_data_i;
      entry_d.busy  = 1'b0;
    end
    if (flush_i) begin
      entry_d.busy = 1'b0;
    end else if (alloc_hit_i) begin
      entry_d.busy = 1'b1;
      entry_d.tag  = alloc_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o  = entry_q;
  assign busy_d_o = entry_d.busy;

endmodule

// File: rtl/tomasulo_regfile.sv
// Register file with Tomasulo rename status, same-cycle CDB bypass on reads.
module tomasulo_regfile
  import tomasulo_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  tomasulo_regfile_if.slave  bus
);

  entry_t                  entries [N_REGISTER];
  logic [N_REGISTER-1:0]   busy_d;
  logic [N_READ-1:0]       rd_in_range;
  cnt_t                    busy_count_q, busy_count_d;

  for (genvar i = 0; i < N_REGISTER; i++) begin : g_entry
    logic alloc_hit;
    assign alloc_hit = bus.alloc_valid && (bus.alloc_num == N_NUMBERS'(i));

    reg_entry u_entry (
      .clk_i       (clk),
      .reset_i     (reset),
      .alloc_hit_i (alloc_hit),
      .alloc_tag_i (bus.alloc_tag),
      .cdb_valid_i (bus.cdb_valid),
      .cdb_tag_i   (bus.cdb_tag),
      .cdb_data_i  (bus.cdb_data),
      .flush_i     (bus.flush),
      .entry_o     (entries[i]),
      .busy_d_o    (busy_d[i])
    );
  end

  // Only a non-power-of-2 register count can see out-of-range numbers.
  if (N_REGISTER == (1 << N_NUMBERS)) begin : g_full_range
    assign rd_in_range = '1;
  end else begin : g_part_range
    for (genvar p = 0; p < N_READ; p++) begin : g_cmp
      assign rd_in_range[p] = 32'(bus.rd_num[p]) < N_REGISTER;
    end
  end

  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    entry_t sel;
    logic   bypass;

    assign sel    = rd_in_range[p] ? entries[bus.rd_num[p]] : '0;
    assign bypass = sel.busy && bus.cdb_valid && (bus.cdb_tag == sel.tag);

    assign bus.rd_value[p] = bypass ? bus.cdb_data : sel.value;
    assign bus.rd_ready[p] = !sel.busy || bypass;
    assign bus.rd_tag[p]   = sel.tag;
  end

  assign busy_count_d = popcount(busy_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_count_q <= '0;
    end else begin
      busy_count_q <= busy_count_d;
    end
  end

  assign bus.busy_count = busy_count_q;

endmodule

// File: tb/tb_tomasulo_regfile.sv
// Directed and randomized checks of tomasulo_regfile against an array-based model.
module tb_tomasulo_regfile;
  import tomasulo_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  logic [15:0] m_val  [8];
  logic        m_busy [8];
  logic [2:0]  m_tag  [8];

  tomasulo_regfile_if bus ();

  tomasulo_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reset           = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_num   = '0;
    bus.alloc_tag   = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_data    = '0;
    bus.flush       = 1'b0;
  endtask

  // Applies the architectural rules to the model, then advances one clock.
  task automatic tick();
    logic [15:0] nv [8];
    logic        nb [8];
    logic [2:0]  nt [8];
    for (int r = 0; r < 8; r++) begin
      nv[r] = m_val[r];
      nb[r] = m_busy[r];
      nt[r] = m_tag[r];
    end
    if (reset) begin
      for (int r = 0; r < 8; r++) begin
        nv[r] = '0;
        nb[r] = 1'b0;
        nt[r] = '0;
      end
    end else begin
      if (bus.cdb_valid) begin
        for (int r = 0; r < 8; r++) begin
          if (m_busy[r] && m_tag[r] == bus.cdb_tag) begin
            nv[r] = bus.cdb_data;
            nb[r] = 1'b0;
          end
        end
      end
      if (bus.flush) begin
        for (int r = 0; r < 8; r++) nb[r] = 1'b0;
      end else if (bus.alloc_valid) begin
        nb[bus.alloc_num] = 1'b1;
        nt[bus.alloc_num] = bus.alloc_tag;
      end
    end
    @(posedge clk);
    for (int r = 0; r < 8; r++) begin
      m_val[r]  = nv[r];
      m_busy[r] = nb[r];
      m_tag[r]  = nt[r];
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc_cycle(input int num, input int tag);
    idle();
    bus.alloc_valid = 1'b1;
    bus.alloc_num   = reg_num_t'(num);
    bus.alloc_tag   = tag_t'(tag);
    tick();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    for (int r = 0; r < 8; r++) begin
      bus.rd_num[0] = reg_num_t'(r);
      #1;
      n_cmp++;
      if (bus.rd_value[0] !== 16'h0 || bus.rd_ready[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_read r%0d: got value=%h ready=%b, want 0000/1", r,
                 bus.rd_value[0], bus.rd_ready[0]);
      end
    end
    n_cmp++;
    if (bus.busy_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d, want 0", bus.busy_count);
    end
  endtask

  task automatic test_rename_broadcast();
    do_reset();
    alloc_cycle(3, 5);
    bus.rd_num[0] = 3'd3;
    #1;
    n_cmp++;
    if (bus.rd_ready[0] !== 1'b0 || bus.rd_tag[0] !== 3'd5 || bus.busy_count !== 4'd1) begin
      n_fail++;
      $display("FAIL rename: got ready=%b tag=%0d count=%0d, want 0/5/1", bus.rd_ready[0],
               bus.rd_tag[0], bus.busy_count);
    end
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd5;
    bus.cdb_data  = 16'hBEEF;
    #1;
    n_cmp++;
    if (bus.rd_ready[0] !== 1'b1 || bus.rd_value[0] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL cdb_bypass: got ready=%b value=%h, want 1/beef", bus.rd_ready[0],
               bus.rd_value[0]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.rd_ready[0] !== 1'b1 || bus.rd_value[0] !== 16'hBEEF || bus.busy_count !== 4'd0)
    begin
      n_fail++;
      $display("FAIL cdb_write: got ready=%b value=%h count=%0d, want 1/beef/0",
               bus.rd_ready[0], bus.rd_value[0], bus.busy_count);
    end
  endtask

  task automatic test_collision();
    do_reset();
    alloc_cycle(2, 1);
    bus.alloc_valid = 1'b1;
    bus.alloc_num   = 3'd2;
    bus.alloc_tag   = 3'd4;
    bus.cdb_valid   = 1'b1;
    bus.cdb_tag     = 3'd1;
    bus.cdb_data    = 16'h0011;
    tick();
    idle();
    bus.rd_num[1] = 3'd2;
    #1;
    n_cmp++;
    if (bus.rd_ready[1] !== 1'b0 || bus.rd_tag[1] !== 3'd4 || bus.rd_value[1] !== 16'h0011 ||
        bus.busy_count !== 4'd1) begin
      n_fail++;
      $display("FAIL collision: got ready=%b tag=%0d value=%h count=%0d, want 0/4/0011/1",
               bus.rd_ready[1], bus.rd_tag[1], bus.rd_value[1], bus.busy_count);
    end
  endtask

  task automatic test_multi_match();
    do_reset();
    alloc_cycle(1, 2);
    alloc_cycle(6, 2);
    alloc_cycle(4, 3);
    n_cmp++;
    if (bus.busy_count !== 4'd3) begin
      n_fail++;
      $display("FAIL multi_pre_count: got %0d, want 3", bus.busy_count);
    end
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd2;
    bus.cdb_data  = 16'h1234;
    tick();
    idle();
    bus.rd_num[0] = 3'd1;
    bus.rd_num[1] = 3'd6;
    bus.rd_num[2] = 3'd4;
    #1;
    n_cmp++;
    if (bus.rd_value[0] !== 16'h1234 || bus.rd_ready[0] !== 1'b1 ||
        bus.rd_value[1] !== 16'h1234 || bus.rd_ready[1] !== 1'b1 ||
        bus.rd_ready[2] !== 1'b0 || bus.busy_count !== 4'd1) begin
      n_fail++;
      $display("FAIL multi_match: got %h/%b %h/%b r4ready=%b count=%0d, want 1234/1 1234/1 0 1",
               bus.rd_value[0], bus.rd_ready[0], bus.rd_value[1], bus.rd_ready[1],
               bus.rd_ready[2], bus.busy_count);
    end
  endtask

  task automatic test_flush();
    logic all_ready;
    do_reset();
    alloc_cycle(1, 1);
    alloc_cycle(2, 2);
    alloc_cycle(5, 3);
    bus.flush       = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_num   = 3'd0;
    bus.alloc_tag   = 3'd7;
    tick();
    idle();
    all_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      bus.rd_num[2] = reg_num_t'(r);
      #1;
      if (bus.rd_ready[2] !== 1'b1) all_ready = 1'b0;
    end
    n_cmp++;
    if (all_ready !== 1'b1 || bus.busy_count !== 4'd0) begin
      n_fail++;
      $display("FAIL flush: got all_ready=%b count=%0d, want 1/0", all_ready, bus.busy_count);
    end
  endtask

  task automatic test_reset_mid();
    logic all_zero;
    do_reset();
    alloc_cycle(3, 5);
    alloc_cycle(7, 6);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd5;
    bus.cdb_data  = 16'hAAAA;
    reset         = 1'b1;
    tick();
    idle();
    all_zero = 1'b1;
    for (int r = 0; r < 8; r++) begin
      bus.rd_num[0] = reg_num_t'(r);
      #1;
      if (bus.rd_value[0] !== 16'h0 || bus.rd_ready[0] !== 1'b1) all_zero = 1'b0;
    end
    n_cmp++;
    if (all_zero !== 1'b1 || bus.busy_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got all_zero=%b count=%0d, want 1/0", all_zero, bus.busy_count);
    end
  endtask

  task automatic test_port_independence();
    do_reset();
    alloc_cycle(3, 6);
    alloc_cycle(5, 1);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd1;
    bus.cdb_data  = 16'h5555;
    tick();
    idle();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 3'd6;
    bus.cdb_data  = 16'h3333;
    bus.rd_num[0] = 3'd3;
    bus.rd_num[1] = 3'd3;
    bus.rd_num[2] = 3'd5;
    #1;
    n_cmp++;
    if (bus.rd_value[0] !== 16'h3333 || bus.rd_ready[0] !== 1'b1 ||
        bus.rd_value[1] !== 16'h3333 || bus.rd_ready[1] !== 1'b1 ||
        bus.rd_value[2] !== 16'h5555 || bus.rd_ready[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL ports: got %h/%b %h/%b %h/%b, want 3333/1 3333/1 5555/1",
               bus.rd_value[0], bus.rd_ready[0], bus.rd_value[1], bus.rd_ready[1],
               bus.rd_value[2], bus.rd_ready[2]);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [15:0] exp_val;
    logic        exp_rdy;
    logic [2:0]  exp_tag;
    int          pick;
    int          cnt;
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      bus.alloc_valid = ($urandom_range(0, 99) < 50);
      bus.alloc_num   = reg_num_t'($urandom_range(0, 7));
      bus.alloc_tag   = tag_t'($urandom_range(0, 7));
      bus.cdb_valid   = ($urandom_range(0, 99) < 60);
      pick            = $urandom_range(0, 7);
      bus.cdb_tag     = (m_busy[pick] && $urandom_range(0, 9) < 8) ? m_tag[pick]
                                                                   : tag_t'($urandom_range(0, 7));
      bus.cdb_data    = data_t'($urandom);
      bus.flush       = ($urandom_range(0, 99) < 4);
      reset           = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < 3; p++) bus.rd_num[p] = reg_num_t'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 3; p++) begin
        pick = int'(bus.rd_num[p]);
        if (!m_busy[pick]) begin
          exp_val = m_val[pick];
          exp_rdy = 1'b1;
        end else if (bus.cdb_valid && bus.cdb_tag == m_tag[pick]) begin
          exp_val = bus.cdb_data;
          exp_rdy = 1'b1;
        end else begin
          exp_val = m_val[pick];
          exp_rdy = 1'b0;
        end
        exp_tag = m_tag[pick];
        n_cmp++;
        if (bus.rd_ready[p] !== exp_rdy || (exp_rdy && bus.rd_value[p] !== exp_val) ||
            (!exp_rdy && bus.rd_tag[p] !== exp_tag)) begin
          n_fail++;
          $display("FAIL rand_read cyc%0d port%0d r%0d: got v=%h rdy=%b tag=%0d, want v=%h rdy=%b tag=%0d",
                   cyc, p, pick, bus.rd_value[p], bus.rd_ready[p], bus.rd_tag[p], exp_val,
                   exp_rdy, exp_tag);
        end
      end
      tick();
      cnt = 0;
      for (int r = 0; r < 8; r++) if (m_busy[r]) cnt++;
      n_cmp++;
      if (int'(bus.busy_count) != cnt) begin
        n_fail++;
        $display("FAIL rand_count cyc%0d: got %0d, want %0d", cyc, bus.busy_count, cnt);
      end
    end
    idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int r = 0; r < 8; r++) begin
      m_val[r]  = '0;
      m_busy[r] = 1'b0;
      m_tag[r]  = '0;
    end
    for (int p = 0; p < 3; p++) bus.rd_num[p] = '0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_rename_broadcast();
    test_collision();
    test_multi_match();
    test_flush();
    test_reset_mid();
    test_port_independence();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tomasulo_regfile.md
# tomasulo_regfile

Architectural register file with Tomasulo rename status for the out-of-order core, sitting between the dispatch stage and the reservation stations. Each register holds a value plus a busy bit and a producer tag. Dispatch renames destination registers, and common-data-bus (CDB) broadcasts retire tags and write values. Read ports are parametrised, and a CDB result broadcast in the current cycle is forwarded to reads in that same cycle.

## Interface
- N_REGISTER, 8, number of architectural registers
- N_NUMBERS, $clog2(N_REGISTER), register-number width
- N_SIZE, 16, data width
- N_READ, 3, number of read ports
- TAG_W, 3, reservation-station tag width
- CNT_W, $clog2(N_REGISTER+1), busy-count width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- rd_num  in  N_READ x N_NUMBERS  register number per read port
- rd_value  out  N_READ x N_SIZE  value per port
- rd_ready  out  N_READ  1 = value valid; 0 = wait on rd_tag
- rd_tag  out  N_READ x TAG_W  producer tag, meaningful only when rd_ready=0
- alloc_valid  in  1  rename request
- alloc_num  in  N_NUMBERS  destination register to rename
- alloc_tag  in  TAG_W  new producer tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcasting tag
- cdb_data  in  N_SIZE  broadcast result
- flush  in  1  squash all pending renames
- busy_count  out  CNT_W  registered count of busy registers

## Operation
- **Storage:** N_REGISTER entries, each holding value, busy and tag.
- **Reset:** every value, busy bit and tag is cleared to 0, and busy_count = 0. The read outputs then show value 0, ready 1 and tag 0.
- **Read (per port, combinational):**
  - Entry not busy: value = entry value, ready = 1.
  - Entry busy, cdb_valid = 1 and cdb_tag == entry tag: value = cdb_data, ready = 1 (same-cycle bypass).
  - Otherwise: ready = 0, tag = entry tag, value = entry value (stale, ignored by consumers).
  - Reads always see the pre-edge state plus the CDB bypass. An alloc in the same cycle never affects that cycle's reads, so a source can be read before its destination is renamed.
- **CDB update:** every entry with busy = 1 and tag == cdb_tag takes value <= cdb_data and busy <= 0. Zero, one or many matches are all legal.
- **Alloc:** entry alloc_num takes busy <= 1 and tag <= alloc_tag.
- **Alloc vs CDB on the same entry, same cycle:** alloc wins, so busy stays 1 with the new tag. The value is still written with cdb_data if the old tag matched.
- **Flush:**
  - All busy bits are cleared and tags are left unchanged.
  - A simultaneous alloc is ignored.
  - A simultaneous CDB value write still applies.
- **busy_count:** the next-state population count of busy bits, registered. It always equals the number of busy entries after the edge.

## Timing
- The read path is purely combinational from rd_num, the CDB inputs and state, with zero latency.
- State changes are visible on reads one cycle after the alloc or CDB edge.
- busy_count updates on the same edge as the busy bits, so its latency is 1 cycle from the request.
- Reset has priority over flush, alloc and CDB.
- Reset asserted mid-operation clears all state on that edge, and pending tags are lost.
- alloc_num and rd_num are always in range (N_REGISTER is a power of 2). For a non-power-of-2 N_REGISTER, out-of-range numbers read as value 0 / ready 1, and an alloc to them is ignored.

## Structure
- **Package:** tomasulo_pkg holds reg_num_t, data_t, tag_t and an entry struct {value, busy, tag}. The reservation stations share it.
- **Sub-module:** reg_entry is one register entry, with inputs for the alloc hit, CDB, flush and reset. It is instantiated N_REGISTER times via generate.
- **Top level:** contains the per-port read muxes with CDB bypass, and the popcount for busy_count.

## Test plan
- **Reset:** reset 1 cycle, then read r0..r7 -> all values 0, all ready 1, busy_count 0.
- **Rename then broadcast:**
  - alloc r3 with tag 5 -> next cycle, a read of r3 gives ready 0, tag 5, busy_count 1.
  - CDB tag 5 with data 0xBEEF -> same-cycle read gives ready 1, value 0xBEEF; the next cycle stays 0xBEEF and busy_count returns to 0.
- **Alloc/CDB collision:** r2 is busy with tag 1; in one cycle, alloc r2 with tag 4 and CDB tag 1 with data 0x0011 -> next cycle r2 reads ready 0, tag 4, and busy_count is unchanged.
- **Multi-match:** r1 and r6 are both busy with tag 2; CDB tag 2 with data 0x1234 -> both read 0x1234 and ready, and busy_count drops by 2.
- **Flush:**
  - With 3 busy registers, assert flush together with an alloc of r0 with tag 7 -> next cycle all are ready, r0 is not busy, busy_count is 0.
  - Assert reset mid-broadcast -> all values are 0.
- **Port independence:** N_READ = 3 ports read r3, r3 and r5 while CDB bypasses r3 only -> ports 0 and 1 get bypass data, and port 2 gets r5's stored value.
